oh_fifo_wr_arbiter: RTL
=======================

// Module: oh_fifo_wr_arbiter
//
// PURPOSE
// Shares the single write port of oh_fifo_generic between N requesters in the wr_clk domain.
// Each requester offers valid/last/data. The block grants one requester at a time,
// round-robin, and holds the grant for a whole packet or at most MAXBURST beats.
// Grant beats go straight to fifo wr_en/din. The block never writes while the FIFO is full.
// It sits between the write-side clients and the FIFO; the read side is untouched.
//
// PARAMETERS
// N         4              number of requesters (>=2)
// DW        104            data width, equal to FIFO DW
// MAXBURST  8              max beats per grant before forced release (>=1)
// BW        $clog2(MAXBURST+1)  beat counter width
//
// PORTS
// clk             in   1      clock (FIFO wr_clk)
// reset           in   1      synchronous, active-high reset
// in_valid        in   N      per-requester data valid
// in_last         in   N      per-requester last beat of packet
// in_data         in   N*DW   per-requester data; requester i at [i*DW +: DW]
// in_ready        out  N      per-requester accept; beat = in_valid[i] & in_ready[i]
// fifo_full       in   1      FIFO full
// fifo_prog_full  in   1      FIFO prog_full
// fifo_wr_en      out  1      FIFO write enable
// fifo_din        out  DW     FIFO write data
// grant           out  N      one-hot current owner, registered; 0 when idle
// busy            out  1      high in LOCK state
//
// BEHAVIOUR
// - Reset (sync, active-high, dominates all):
//   state=IDLE, grant=0, beat_cnt=0, rr_ptr=N-1 (requester 0 has highest priority first).
//   Outputs in_ready=0, fifo_wr_en=0, busy=0. An in-flight packet is abandoned.
// - IDLE: if |in_valid and !fifo_prog_full, pick the first valid requester searching
//   rr_ptr+1, rr_ptr+2, ... modulo N.
//   Next cycle: grant=onehot(winner), state=LOCK, beat_cnt=0.
//   No transfer happens in IDLE; arbitration costs 1 cycle of latency.
//   fifo_prog_full high blocks new grants only.
// - LOCK, owner g:
//   in_ready[g] = ~fifo_full (combinational); in_ready of every other requester = 0.
//   beat = in_valid[g] & ~fifo_full. fifo_wr_en = beat. fifo_din = in_data[g] (combinational mux).
//   fifo_din = 0 when no grant.
//   On a beat, beat_cnt increments.
//   Release when a beat has in_last[g]=1, or when the beat makes beat_cnt reach MAXBURST.
//   On release: next cycle state=IDLE, grant=0, rr_ptr=g.
//   If in_valid[g] drops mid-packet, the grant is held; there is no timeout.
//   fifo_prog_full is ignored while in LOCK.
// - Back-to-back packets: minimum 1 idle cycle between grants.
//   Requester g gets lowest priority in the next arbitration.
// - Invariants:
//   fifo_wr_en=1 never while fifo_full=1.
//   grant is one-hot or zero.
//   At most one bit of in_ready is high.
//   Beat count per grant is <= MAXBURST.
// - Data ordering: beats from one requester keep their order.
//   Packets longer than MAXBURST are split across grants, interleaved with other requesters.
//
// TESTING
// 1. Reset, then req0 sends 3 beats A,B,C, last on C.
//    -> grant=0001 on cycle 1, wr_en on 3 consecutive cycles, FIFO holds A,B,C, then IDLE and grant=0.
// 2. All 4 requesters send 1-beat packets continuously.
//    -> grant sequence 0001,0010,0100,1000,0001; each written once per round.
// 3. req1 sends a 20-beat packet with MAXBURST=8, req2 waiting.
//    -> 8 beats of req1, then req2's packet, then req1 beats 9..16.
// 4. fifo_full forced high for 5 cycles mid-packet.
//    -> in_ready=0 and wr_en=0 for those 5 cycles, no beat lost or duplicated, resume on deassert.
// 5. fifo_prog_full high in IDLE with req3 valid.
//    -> no grant until prog_full drops. With prog_full rising in LOCK, the packet completes.
// 6. reset asserted on beat 2 of a 4-beat packet.
//    -> next cycle grant=0, wr_en=0, rr_ptr=N-1, so req0 wins the next arbitration.

Source files
------------

// File: rtl/oh_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oh_fifo_wr_arbiter
// Purpose  : Round-robin, packet-locked arbiter sharing one FIFO write port
//            among N write-side requesters.
// Revision : 1.0 - initial release
// ============================================================================
module oh_fifo_wr_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 104,
  parameter int MAXBURST = 8,
  parameter int BW       = $clog2(MAXBURST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_valid,
  input  logic [N-1:0]      in_last,
  input  logic [N*DW-1:0]   in_data,
  output logic [N-1:0]      in_ready,
  input  logic              fifo_full,
  input  logic              fifo_prog_full,
  output logic              fifo_wr_en,
  output logic [DW-1:0]     fifo_din,
  output logic [N-1:0]      grant,
  output logic              busy
);

  localparam int           c_PW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] c_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          r_state,    w_state_nxt;
  logic [N-1:0]    r_grant,    w_grant_nxt;
  logic [c_PW-1:0] r_owner,    w_owner_nxt;
  logic [c_PW-1:0] r_rr_ptr,   w_rr_ptr_nxt;
  logic [BW-1:0]   r_beat_cnt, w_beat_cnt_nxt;

  logic            w_arb_found;
  logic [c_PW-1:0] w_arb_idx;
  logic [c_PW-1:0] w_scan;
  logic            w_beat;
  logic            w_release;
  logic [BW-1:0]   w_cnt_inc;

  // Search starts just after the last owner, so it gets lowest priority.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_scan      = '0;
    for (int k = 1; k <= N; k++) begin
      w_scan = c_PW'((int'(r_rr_ptr) + k) % N);
      if (!w_arb_found && in_valid[w_scan]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_scan;
      end
    end
  end

  assign w_beat    = (r_state == ST_LOCK) & in_valid[r_owner] & ~fifo_full;
  assign w_cnt_inc = r_beat_cnt + BW'(1);
  assign w_release = w_beat & (in_last[r_owner] | (w_cnt_inc == BW'(MAXBURST)));

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_found && !fifo_prog_full) begin
          w_state_nxt    = ST_LOCK;
          w_grant_nxt    = c_ONE << w_arb_idx;
          w_owner_nxt    = w_arb_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      ST_LOCK: begin
        if (w_release) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_rr_ptr_nxt   = r_owner;
          w_beat_cnt_nxt = '0;
        end else if (w_beat) begin
          w_beat_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= c_PW'(N - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // r_grant is all-zero outside LOCK, so it gates ready and data directly.
  assign in_ready   = r_grant & {N{~fifo_full}};
  assign fifo_wr_en = w_beat;
  assign fifo_din   = (r_state == ST_LOCK) ? in_data[r_owner*DW +: DW] : '0;
  assign grant      = r_grant;
  assign busy       = (r_state == ST_LOCK);

endmodule
`default_nettype wire
